// File: rtl/sram_pkg.sv
// Shared types and board timing defaults for the asynchronous SRAM initiator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD
    } state_t;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 8;

    // 50 MHz board clock: one 20 ns cycle already covers the 10 ns access time
    localparam int RD_CYC_DEF = 1;
    localparam int WS_CYC_DEF = 1;
    localparam int WP_CYC_DEF = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_io_buf.sv
// Tri-state DQ driver plus read-data capture register.
// Latency: capture lands one cycle after cap is asserted; drive follows oe combinationally.
// Backpressure: none, slaved entirely to the controller FSM.
module sram_io_buf
    import sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    input  logic              cap,
    output logic [DATA_W-1:0] din_q,
    inout  wire  [DATA_W-1:0] dq
);

    assign dq = oe ? dout : {DATA_W{1'bz}};

    // Holds the last read byte until the next read completes
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
        end else if (cap) begin
            din_q <= dq;
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Single-beat bus-to-async-SRAM initiator with registered strobes and parameterised wait states.
// Latency: read RD_CYC cycles accept->rvalid_o, write WS_CYC+WP_CYC+1 cycles accept->wack_o.
// Backpressure: ready_o low from acceptance until the cycle the completion pulse is high.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_CYC = RD_CYC_DEF,
    parameter int WS_CYC = WS_CYC_DEF,
    parameter int WP_CYC = WP_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdat_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdat_o,
    output logic              rvalid_o,
    output logic              wack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    inout  wire  [DATA_W-1:0] sram_dat_io
);

    localparam int CNT_W = $clog2(max3(RD_CYC, WS_CYC, WP_CYC)) + 1;
    localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WS_LD = CNT_W'(WS_CYC - 1);
    localparam logic [CNT_W-1:0] WP_LD = CNT_W'(WP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drv_q, drv_d;
    logic              rvalid_q, rvalid_d;
    logic              wack_q, wack_d;
    logic              cap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            drv_q    <= 1'b0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            drv_q    <= drv_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
        end
    end

    // Every strobe is computed one state ahead so the pins come straight from flops
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        drv_d    = drv_q;
        rvalid_d = 1'b0;
        wack_d   = 1'b0;
        cap      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    addr_d = addr_i;
                    ce_n_d = 1'b0;
                    if (we_i) begin
                        wdat_d  = wdat_i;
                        drv_d   = 1'b1;
                        cnt_d   = WS_LD;
                        state_d = ST_WSETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LD;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cap      = 1'b1;
                    rvalid_d = 1'b1;
                    ce_n_d   = 1'b1;
                    oe_n_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WSETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    we_n_d  = 1'b0;
                    cnt_d   = WP_LD;
                    state_d = ST_WPULSE;
                end
            end
            ST_WPULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    we_n_d  = 1'b1;
                    state_d = ST_WHOLD;
                end
            end
            ST_WHOLD: begin
                // WE# rose at the start of this cycle; address and data held through it for hold time
                ce_n_d  = 1'b1;
                drv_d   = 1'b0;
                wack_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sram_io_buf #(
        .DATA_W (DATA_W)
    ) u_io_buf (
        .clk   (clk_i),
        .rst   (rst_i),
        .oe    (drv_q),
        .dout  (wdat_q),
        .cap   (cap),
        .din_q (rdat_o),
        .dq    (sram_dat_io)
    );

    assign ready_o     = (state_q == ST_IDLE) && !rst_i;
    assign rvalid_o    = rvalid_q;
    assign wack_o      = wack_q;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;

endmodule
